// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t   : arbiter FSM states
//   PORT_A/B  : requester identifiers (also the encoding of the owner output)
//   SM_*      : data_mem sign_mask values (bit SM_SIGNED_BIT selects signed loads)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [3:0] SM_BYTE = 4'b0001;
  localparam logic [3:0] SM_HALF = 4'b0011;
  localparam logic [3:0] SM_WORD = 4'b0111;
  localparam int unsigned SM_SIGNED_BIT = 3;

endpackage

// File: rtl/dmem_arbiter_arb.sv
// Combinational two-way grant.
//   req_a, req_b : pending requests
//   last_owner   : port served by the most recent completed access
//   grant_vld    : some port is requesting
//   grant_id     : port to serve (PORT_A / PORT_B)
// With FIXED_PRIO != 0 port A wins every tie; otherwise a tie goes to the
// port that was not served last.
module arb2_rr
  import dmem_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic req_a,
  input  logic req_b,
  input  logic last_owner,
  output logic grant_vld,
  output logic grant_id
);

  always_comb begin
    grant_vld = req_a | req_b;
    grant_id  = PORT_A;
    if (req_a && req_b) begin
      grant_id = (FIXED_PRIO != 0) ? PORT_A : ~last_owner;
    end else if (req_b) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_mem between port A (load/store unit) and port B
// (debug/DMA loader). One access at a time: grant in IDLE, one-cycle
// memread/memwrite strobe in ISSUE, wait out clk_stall in WAIT (bounded by
// TIMEOUT), then a one-cycle done pulse to the owner in RESP.
//   a_* / b_*   : requester ports (req held until done; done/rdata/err
//                 are valid for one cycle)
//   mem_*       : data_mem interface; address/data/mask held from ISSUE
//                 through RESP, zero in IDLE
//   busy, owner : arbiter not idle / port currently served
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_sign_mask,
  output logic        a_done,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_sign_mask,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        busy,
  output logic        owner
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              grant_vld;
  logic              grant_id;
  logic              resp;

  arb2_rr #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .req_a     (a_req),
    .req_b     (b_req),
    .last_owner(last_owner_q),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant_id;
          if (grant_id == PORT_B) begin
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            mask_d  = b_sign_mask;
          end else begin
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            mask_d  = a_sign_mask;
          end
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!mem_clk_stall) begin
          rdata_d = we_q ? '0 : mem_read_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= PORT_B;
      cnt_q        <= '0;
      owner_q      <= PORT_A;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // All outputs decode from registered state, so an asynchronous reset
  // clears them immediately.
  always_comb begin
    busy           = (state_q != IDLE);
    resp           = (state_q == RESP);
    owner          = busy & owner_q;
    mem_memwrite   = (state_q == ISSUE) &  we_q;
    mem_memread    = (state_q == ISSUE) & ~we_q;
    mem_addr       = busy ? addr_q  : '0;
    mem_write_data = busy ? wdata_q : '0;
    mem_sign_mask  = busy ? mask_q  : '0;
    a_done         = resp & (owner_q == PORT_A);
    b_done         = resp & (owner_q == PORT_B);
    a_rdata        = a_done ? rdata_q : '0;
    b_rdata        = b_done ? rdata_q : '0;
    a_err          = a_done & err_q;
    b_err          = b_done & err_q;
  end

endmodule
